// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the RV64 datapath.
//
// Signals
//   opcode       IR[6:0], stable from DECODE until the next fetch completes
//   mem_ready    shared instruction/data memory finishes the access this cycle
//   pc_write .. alu_op   per-step datapath controls
//   illegal_insn one-cycle pulse when DECODE sees an unsupported opcode
//   fault        sticky memory-timeout flag
//   instret      retired instruction count
//
// Memory handshake: mem_read/mem_write are level strobes.  The sequencer
// raises one on entering a memory step and holds it, unchanged, on every
// cycle until mem_ready is high at a rising clock edge.  That edge completes
// the access and moves the sequencer on.  mem_ready is ignored while no
// strobe is up.
//
// Modports
//   master  the sequencer (drives controls, reads opcode/mem_ready)
//   slave   the datapath/memory side
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal_insn;
    logic             fault;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal_insn, fault, instret
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal_insn, fault, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style sequencing FSM for the multi-cycle RV64 datapath.
// Supports R-type, ld, sd and beq; anything else is flagged illegal and
// skipped.  A memory step that sees MEM_WAIT_MAX consecutive not-ready
// cycles parks the sequencer in FAULT until reset.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   bus        control bus (master side), see multicycle_control_if
//   dbg_state  current state encoding, for observation only
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15,   // 1..255
    parameter int CNT_W        = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    multicycle_control_if.master bus,
    output logic [3:0]          dbg_state
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC     = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        FAULT    = 4'd10
    } state_e;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // wait_q counts not-ready cycles already spent in the current memory
    // step; the current cycle is the MEM_WAIT_MAX-th when it reads MAX-1.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             mem_step;
    logic             timeout;

    always_comb begin
        state_d            = state_q;
        retire             = 1'b0;
        mem_step           = 1'b0;
        bus.pc_write       = 1'b0;
        bus.pc_write_cond  = 1'b0;
        bus.pc_source      = 1'b0;
        bus.i_or_d         = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.ir_write       = 1'b0;
        bus.mem_to_reg     = 1'b0;
        bus.reg_write      = 1'b0;
        bus.alu_src_a      = 1'b0;
        bus.alu_src_b      = 2'b00;
        bus.alu_op         = 2'b00;
        bus.illegal_insn   = 1'b0;
        bus.fault          = 1'b0;
        timeout            = (wait_q == WAIT_LAST) && !bus.mem_ready;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_step      = 1'b1;
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;     // PC + 4
                // IR and PC load only on the completing cycle.
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
                else if (timeout)  state_d = FAULT;
            end
            DECODE: begin
                bus.alu_src_b = 2'b10;     // PC + imm: branch target into ALUOut
                case (bus.opcode)
                    OP_LD, OP_SD: state_d = MEM_ADDR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    default: begin
                        bus.illegal_insn = 1'b1;
                        state_d          = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_LD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_step     = 1'b1;
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = MEM_WB;
                else if (timeout)  state_d = FAULT;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                mem_step      = 1'b1;
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = FAULT;
                end
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = ALU_WB;
            end
            ALU_WB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 1'b1;
                retire            = 1'b1;
                state_d           = FETCH;
            end
            FAULT: bus.fault = 1'b1;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)           wait_d = 8'd0;
        else if (mem_step && !bus.mem_ready) wait_d = wait_q + 8'd1;
        else                              wait_d = wait_q;

        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wait_q    <= 8'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    assign bus.instret = instret_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class,
// memory wait/timeout boundaries and asynchronous reset.
module tb_multicycle_control;
    localparam int CNT_W = 32;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_MEM_ADDR = 4'd3, S_MEM_RD = 4'd4, S_MEM_WB = 4'd5,
                           S_MEM_WR = 4'd6, S_EXEC = 4'd7, S_ALU_WB = 4'd8,
                           S_BRANCH = 4'd9, S_FAULT = 4'd10;

    // ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
    //         ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
    //         alu_op[1:0], illegal_insn, fault}
    localparam logic [15:0] C_ZERO     = 16'h0000;
    localparam logic [15:0] C_FETCH_W  = 16'h0810;
    localparam logic [15:0] C_FETCH_R  = 16'h8A10;
    localparam logic [15:0] C_DECODE   = 16'h0020;
    localparam logic [15:0] C_ILLEGAL  = 16'h0022;
    localparam logic [15:0] C_MEM_ADDR = 16'h0060;
    localparam logic [15:0] C_MEM_RD   = 16'h1800;
    localparam logic [15:0] C_MEM_WB   = 16'h0180;
    localparam logic [15:0] C_MEM_WR   = 16'h1400;
    localparam logic [15:0] C_EXEC     = 16'h0048;
    localparam logic [15:0] C_ALU_WB   = 16'h0080;
    localparam logic [15:0] C_BRANCH   = 16'h6044;
    localparam logic [15:0] C_FAULT    = 16'h0001;

    localparam logic [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011,
                           OP_R = 7'b0110011, OP_BEQ = 7'b1100011,
                           OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset_n;
    logic [3:0] dbg_state;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.MEM_WAIT_MAX(15), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    wire [15:0] ctrl = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                        bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                        bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                        bus.illegal_insn, bus.fault};

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_instret;

    // Per-test vector tables: one entry per clock cycle.
    logic [3:0]  es [0:31];
    logic [15:0] ec [0:31];
    logic        er [0:31];
    int          n;

    task automatic clear_tables();
        n = 0;
    endtask

    task automatic push(input logic [3:0] s, input logic [15:0] c, input logic r);
        es[n] = s; ec[n] = c; er[n] = r; n++;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode = 7'd0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_instret = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.opcode = OP_R;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || ctrl !== C_ZERO || bus.instret !== '0) begin
            errors++;
            $display("FAIL reset: state=%0d ctrl=%h instret=%0d, required state=%0d ctrl=%h instret=0",
                     dbg_state, ctrl, bus.instret, S_IDLE, C_ZERO);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_instret = '0;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || ctrl !== C_ZERO) begin
            errors++;
            $display("FAIL idle_cycle: state=%0d ctrl=%h, required state=%0d ctrl=%h",
                     dbg_state, ctrl, S_IDLE, C_ZERO);
        end
        @(posedge clk);
        #1;
    endtask

    // Runs the current table (starting just after a rising edge) and then
    // checks instret against the bench's own running count.
    task automatic run_table(input string name, input logic [6:0] op);
        bus.opcode = op;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = er[i];
            @(negedge clk);
            checks++;
            if (dbg_state !== es[i] || ctrl !== ec[i]) begin
                errors++;
                $display("FAIL %s cycle %0d: state=%0d ctrl=%h, required state=%0d ctrl=%h",
                         name, i, dbg_state, ctrl, es[i], ec[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.instret !== exp_instret) begin
            errors++;
            $display("FAIL %s instret: got %0d, required %0d", name, bus.instret, exp_instret);
        end
    endtask

    task automatic test_r_type();
        clear_tables();
        push(S_FETCH, C_FETCH_R, 1'b1);
        push(S_DECODE, C_DECODE, 1'b1);
        push(S_EXEC, C_EXEC, 1'b1);
        push(S_ALU_WB, C_ALU_WB, 1'b1);
        exp_instret = exp_instret + 1;
        run_table("r_type", OP_R);
    endtask

    task automatic test_ld();
        clear_tables();
        push(S_FETCH, C_FETCH_R, 1'b1);
        push(S_DECODE, C_DECODE, 1'b1);
        push(S_MEM_ADDR, C_MEM_ADDR, 1'b1);
        push(S_MEM_RD, C_MEM_RD, 1'b1);
        push(S_MEM_WB, C_MEM_WB, 1'b1);
        exp_instret = exp_instret + 1;
        run_table("ld", OP_LD);
    endtask

    task automatic test_sd_wait();
        clear_tables();
        push(S_FETCH, C_FETCH_R, 1'b1);
        push(S_DECODE, C_DECODE, 1'b1);
        push(S_MEM_ADDR, C_MEM_ADDR, 1'b1);
        push(S_MEM_WR, C_MEM_WR, 1'b0);
        push(S_MEM_WR, C_MEM_WR, 1'b0);
        push(S_MEM_WR, C_MEM_WR, 1'b0);
        push(S_MEM_WR, C_MEM_WR, 1'b1);
        exp_instret = exp_instret + 1;
        run_table("sd_wait", OP_SD);
    endtask

    task automatic test_beq();
        clear_tables();
        push(S_FETCH, C_FETCH_R, 1'b1);
        push(S_DECODE, C_DECODE, 1'b1);
        push(S_BRANCH, C_BRANCH, 1'b1);
        exp_instret = exp_instret + 1;
        run_table("beq", OP_BEQ);
    endtask

    task automatic test_illegal();
        clear_tables();
        push(S_FETCH, C_FETCH_R, 1'b1);
        push(S_DECODE, C_ILLEGAL, 1'b1);
        push(S_FETCH, C_FETCH_W, 1'b0);   // back in FETCH, pulse gone
        run_table("illegal", OP_BAD);
    endtask

    // Ready arrives on the 15th waiting cycle: must not fault.  The tail of
    // the fetch wait (14 cycles) is absorbed into the same table.
    task automatic test_ready_on_last();
        clear_tables();
        for (int i = 0; i < 13; i++) push(S_FETCH, C_FETCH_W, 1'b0);
        push(S_FETCH, C_FETCH_R, 1'b1);
        push(S_DECODE, C_DECODE, 1'b1);
        push(S_EXEC, C_EXEC, 1'b1);
        push(S_ALU_WB, C_ALU_WB, 1'b1);
        exp_instret = exp_instret + 1;
        // The preceding illegal test already spent one not-ready FETCH cycle.
        run_table("ready_on_last", OP_R);
    endtask

    // Waits in two different memory steps must not accumulate.
    task automatic test_wait_clear();
        clear_tables();
        for (int i = 0; i < 10; i++) push(S_FETCH, C_FETCH_W, 1'b0);
        push(S_FETCH, C_FETCH_R, 1'b1);
        push(S_DECODE, C_DECODE, 1'b1);
        push(S_MEM_ADDR, C_MEM_ADDR, 1'b1);
        for (int i = 0; i < 10; i++) push(S_MEM_RD, C_MEM_RD, 1'b0);
        push(S_MEM_RD, C_MEM_RD, 1'b1);
        push(S_MEM_WB, C_MEM_WB, 1'b1);
        exp_instret = exp_instret + 1;
        run_table("wait_clear", OP_LD);
    endtask

    task automatic test_fault();
        clear_tables();
        for (int i = 0; i < 15; i++) push(S_FETCH, C_FETCH_W, 1'b0);
        for (int i = 0; i < 5; i++) push(S_FAULT, C_FAULT, 1'b1);
        run_table("fault", OP_R);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.opcode = OP_R;
        bus.mem_ready = 1'b1;
        repeat (5) @(posedge clk);           // IDLE, FETCH, DECODE, EXEC, ALU_WB
        #1 bus.opcode = OP_LD;
        repeat (3) @(posedge clk);           // FETCH, DECODE, MEM_ADDR
        #1 bus.mem_ready = 1'b0;
        @(posedge clk);                      // now in MEM_RD, waiting
        @(negedge clk);
        checks++;
        if (dbg_state !== S_MEM_RD || ctrl !== C_MEM_RD || bus.instret !== 1) begin
            errors++;
            $display("FAIL pre_reset: state=%0d ctrl=%h instret=%0d, required state=%0d ctrl=%h instret=1",
                     dbg_state, ctrl, bus.instret, S_MEM_RD, C_MEM_RD);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (dbg_state !== S_IDLE || ctrl !== C_ZERO || bus.instret !== '0) begin
            errors++;
            $display("FAIL async_reset: state=%0d ctrl=%h instret=%0d, required state=%0d ctrl=%h instret=0",
                     dbg_state, ctrl, bus.instret, S_IDLE, C_ZERO);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_instret = '0;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || ctrl !== C_ZERO) begin
            errors++;
            $display("FAIL post_reset_idle: state=%0d ctrl=%h, required state=%0d ctrl=%h",
                     dbg_state, ctrl, S_IDLE, C_ZERO);
        end
        @(posedge clk);
        #1;
        clear_tables();
        push(S_FETCH, C_FETCH_R, 1'b1);
        push(S_DECODE, C_DECODE, 1'b1);
        push(S_BRANCH, C_BRANCH, 1'b1);
        exp_instret = exp_instret + 1;
        run_table("after_reset_beq", OP_BEQ);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        bus.opcode = 7'd0;
        bus.mem_ready = 1'b0;
        exp_instret = '0;
        test_reset();
        test_r_type();
        test_ld();
        test_sd_wait();
        test_beq();
        test_illegal();
        test_ready_on_last();
        test_wait_clear();
        test_fault();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencing FSM for the multi-cycle RV64 datapath.
- Replaces single-cycle opcode decode for R-type, ld, sd and beq.
- Drives PC, IR, memory, register-file and ALU-mux controls per step.
- Handles a ready/strobe handshake to the shared instruction/data memory, with timeout, fault and retired-instruction counting.

Parameters:
- MEM_WAIT_MAX, 15: max consecutive not-ready cycles in a memory state before fault (1..255).
- CNT_W, 32: width of instret counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- mem_ready  in  1  memory completes access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (gated externally).
- pc_source  out  1  0=ALU result, 1=ALUOut (branch target).
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  latch IR/MDR.
- mem_to_reg  out  1  writeback: 0=ALUOut, 1=MDR.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  0=PC, 1=rs1.
- alu_src_b  out  2  00=rs2, 01=const 4, 10=immediate.
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded.
- illegal_insn  out  1  one-cycle pulse on unsupported opcode.
- fault  out  1  sticky memory-timeout flag.
- instret  out  CNT_W  retired instruction count.

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, FAULT.
- reset_n low (async): state=IDLE, wait counter=0, instret=0, fault=0; all outputs 0.
- IDLE: all outputs 0; always -> FETCH next edge.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0. ir_write=pc_write=mem_ready (Mealy on mem_ready only). mem_ready=1 -> DECODE; else stay.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - opcode 0000011 or 0100011 -> MEM_ADDR.
  - 0110011 -> EXEC; 1100011 -> BRANCH.
  - Any other -> FETCH with illegal_insn=1 this cycle; instret unchanged.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_RD if opcode=0000011, else MEM_WR. opcode is held stable by IR.
- MEM_RD: mem_read=1, i_or_d=1; mem_ready -> MEM_WB, else stay.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; mem_ready -> FETCH, else stay.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1 -> FETCH.
- Any output not listed for a state is 0.
- Memory strobes stay constant across wait cycles.
- Latency with mem_ready always 1: R 4, ld 5, sd 4, beq 3 cycles.
- Wait counter:
  - Increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on any state change.
  - When it equals MEM_WAIT_MAX with mem_ready still 0 -> FAULT.
  - mem_ready=1 on that same cycle wins: normal transition.
- FAULT: all outputs 0 except fault=1; terminal until reset.
- instret += 1 (wraps mod 2^CNT_W) on transitions MEM_WB->FETCH, MEM_WR->FETCH (with mem_ready), ALU_WB->FETCH, BRANCH->FETCH.
- Reset mid-instruction: immediate IDLE, counters cleared, no strobe glitch after reset_n falls.

Test Plan:
- Reset, then one idle cycle, mem_ready=1, opcode=0110011: states IDLE,FETCH,DECODE,EXEC,ALU_WB. reg_write=1 in cycle 4 of instruction; instret=1.
- ld (0000011), mem_ready=1: 5 cycles. MEM_RD has i_or_d=1 and mem_read=1; MEM_WB has reg_write=1 and mem_to_reg=1; instret+1.
- sd (0100011), mem_ready low 3 cycles in MEM_WR: mem_write held 4 cycles, no reg_write, completes on ready; instret+1.
- beq (1100011): BRANCH has pc_write_cond=1, pc_source=1, alu_op=01; 3 cycles total.
- opcode 1111111: illegal_insn pulses 1 cycle in DECODE, returns to FETCH, instret unchanged.
- mem_ready=0 in FETCH for 15 cycles (MEM_WAIT_MAX=15): FAULT; fault=1 and all strobes 0 until reset. mem_ready=1 on the 15th cycle instead -> DECODE. reset_n pulse mid-MEM_RD -> IDLE, instret=0.
